// File: rtl/cpu16_pkg.sv
// Shared CPU encodings: instruction classes from cpu16_decode, ALU op codes, sequencer states.
package cpu16_pkg;

  localparam logic [3:0] ICNT_NOP  = 4'h0;
  localparam logic [3:0] ICNT_ADD  = 4'h1;
  localparam logic [3:0] ICNT_SUB  = 4'h2;
  localparam logic [3:0] ICNT_AND  = 4'h3;
  localparam logic [3:0] ICNT_OR   = 4'h4;
  localparam logic [3:0] ICNT_JMP  = 4'h8;
  localparam logic [3:0] ICNT_HALT = 4'hF;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  function automatic logic [1:0] alu_op_for(input logic [3:0] icnt);
    logic [1:0] op;
    case (icnt)
      ICNT_SUB: op = ALU_SUB;
      ICNT_AND: op = ALU_AND;
      ICNT_OR:  op = ALU_OR;
      default:  op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/cpu16_sequencer.sv
// Multi-cycle fetch/decode/exec/writeback controller for the 16-bit CPU.
// Holds PC and IR; steers the ALU op, regfile write enable and PC updates.
module cpu16_sequencer
  import cpu16_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              JMP_W    = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  output logic            MEM_REQ,
  output logic [PC_W-1:0] MEM_ADDR,
  input  logic            MEM_ACK,
  input  logic [15:0]     MEM_RDATA,
  output logic [15:0]     IR,
  input  logic [3:0]      ICNT,
  output logic [1:0]      ALU_OP,
  output logic            REG_WE,
  output logic            HALTED,
  output logic            ILLEGAL,
  output logic [2:0]      STATE
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [1:0]      alu_op_q, alu_op_d;
  logic            mem_req_q, mem_req_d;
  logic            reg_we_q, reg_we_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    alu_op_d  = alu_op_q;
    halted_d  = halted_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (START) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (MEM_ACK) begin
          ir_d    = MEM_RDATA;
          pc_d    = pc_q + PC_W'(1);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (ICNT)
          ICNT_NOP: state_d = ST_FETCH;
          ICNT_ADD, ICNT_SUB, ICNT_AND, ICNT_OR: begin
            alu_op_d = alu_op_for(ICNT);
            state_d  = ST_EXEC;
          end
          // Jump target replaces the PC+1 taken on the fetch edge.
          ICNT_JMP: begin
            pc_d    = PC_W'(ir_q[JMP_W-1:0]);
            state_d = ST_FETCH;
          end
          ICNT_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            halted_d  = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_HALT;
          end
        endcase
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
    // Strobes are registered, so derive them from the state being entered.
    mem_req_d = (state_d == ST_FETCH);
    reg_we_d  = (state_d == ST_WB);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      alu_op_q  <= ALU_ADD;
      mem_req_q <= 1'b0;
      reg_we_q  <= 1'b0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      alu_op_q  <= alu_op_d;
      mem_req_q <= mem_req_d;
      reg_we_q  <= reg_we_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
    end
  end

  assign MEM_REQ  = mem_req_q;
  assign MEM_ADDR = pc_q;
  assign IR       = ir_q;
  assign ALU_OP   = alu_op_q;
  assign REG_WE   = reg_we_q;
  assign HALTED   = halted_q;
  assign ILLEGAL  = illegal_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_cpu16_sequencer.sv
// Scoreboard bench for cpu16_sequencer: random instruction stream against an architectural model.
module tb_cpu16_sequencer;

  logic        CLK = 1'b0;
  logic        RST, START, MEM_ACK;
  logic [15:0] MEM_RDATA;
  logic        MEM_REQ, REG_WE, HALTED, ILLEGAL;
  logic [15:0] MEM_ADDR, IR;
  logic [3:0]  ICNT;
  logic [1:0]  ALU_OP;
  logic [2:0]  STATE;

  logic        w_req, w_we, w_halted, w_illegal;
  logic [15:0] w_addr, w_ir;
  logic [3:0]  w_icnt;
  logic [1:0]  w_alu_op;
  logic [2:0]  w_state;

  always #5 CLK = ~CLK;

  // The bench stands in for cpu16_decode: class code is the top nibble.
  assign ICNT   = IR[15:12];
  assign w_icnt = w_ir[15:12];

  cpu16_sequencer u_dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .IR(IR), .ICNT(ICNT), .ALU_OP(ALU_OP),
    .REG_WE(REG_WE), .HALTED(HALTED), .ILLEGAL(ILLEGAL), .STATE(STATE)
  );

  // Second instance starting at the top of the address space, run in lockstep.
  cpu16_sequencer #(.RESET_PC(16'hFFFF)) u_wrap (
    .CLK(CLK), .RST(RST), .START(START), .MEM_REQ(w_req), .MEM_ADDR(w_addr),
    .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA), .IR(w_ir), .ICNT(w_icnt), .ALU_OP(w_alu_op),
    .REG_WE(w_we), .HALTED(w_halted), .ILLEGAL(w_illegal), .STATE(w_state)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [15:0] exp_addr[$];
  int          exp_gap[$];
  logic [15:0] exp_ir[$];
  logic [1:0]  exp_op[$];
  logic [15:0] pc_m, ir_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: pops expectations whenever the DUT starts a fetch, decodes or writes back.
  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0, prev_we = 1'b0;
  logic [15:0] held = '0;
  int          last_fetch = 0;
  int          g;
  logic [15:0] e16;
  logic [1:0]  e2;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (MEM_REQ && !prev_req) begin
        if (exp_addr.size() == 0) begin
          total++; bad++;
          $display("FAIL fetch_unexpected: got fetch at %0h expected none", MEM_ADDR);
        end else begin
          held = exp_addr.pop_front();
          g    = exp_gap.pop_front();
          chk("fetch_addr", MEM_ADDR, held);
          if (g >= 0) chk("fetch_gap", cyc - last_fetch, g);
        end
        last_fetch = cyc;
      end else if (MEM_REQ) begin
        chk("addr_stable", MEM_ADDR, held);
      end
      if (STATE == 3'd2) begin
        if (exp_ir.size() == 0) begin
          total++; bad++;
          $display("FAIL decode_unexpected: got IR %0h expected no decode", IR);
        end else begin
          e16 = exp_ir.pop_front();
          chk("ir_decode", IR, e16);
        end
      end
      if (STATE == 3'd3 && exp_op.size() > 0) chk("alu_op_exec", ALU_OP, exp_op[0]);
      if (REG_WE) begin
        if (exp_op.size() == 0) begin
          total++; bad++;
          $display("FAIL we_unexpected: got REG_WE=1 expected 0");
        end else begin
          e2 = exp_op.pop_front();
          chk("alu_op_wb", ALU_OP, e2);
        end
        chk("we_state", STATE, 3'd4);
        chk("we_pulse", prev_we, 1'b0);
      end
    end
    prev_req = MEM_REQ;
    prev_we  = REG_WE;
  end

  task automatic model_init();
    exp_addr.delete(); exp_gap.delete(); exp_ir.delete(); exp_op.delete();
    pc_m = 16'h0000;
    ir_m = 16'h0000;
    exp_addr.push_back(16'h0000);
    exp_gap.push_back(-1);
  endtask

  task automatic reset_and_start();
    mon_en = 1'b0;
    RST = 1'b1; START = 1'b0; MEM_ACK = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    model_init();
    mon_en = 1'b1;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!MEM_REQ && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (!MEM_REQ) begin
      total++; bad++;
      $display("FAIL req_timeout: got MEM_REQ=0 expected 1 within 50 cycles");
    end
  endtask

  // Serve one fetch with the given wait and record what the architecture must do next.
  task automatic do_instr(input logic [15:0] w, input int waitc);
    logic [3:0] c;
    int gap;
    c = w[15:12];
    wait_req();
    repeat (waitc) begin
      @(posedge CLK); #1;
      chk("ir_hold", IR, ir_m);
    end
    MEM_ACK = 1'b1;
    MEM_RDATA = w;
    exp_ir.push_back(w);
    ir_m = w;
    pc_m = pc_m + 16'd1;
    gap = -1;
    case (c)
      4'h0: gap = waitc + 2;
      4'h1: begin exp_op.push_back(2'b00); gap = waitc + 4; end
      4'h2: begin exp_op.push_back(2'b01); gap = waitc + 4; end
      4'h3: begin exp_op.push_back(2'b10); gap = waitc + 4; end
      4'h4: begin exp_op.push_back(2'b11); gap = waitc + 4; end
      4'h8: begin pc_m = {8'h00, w[7:0]}; gap = waitc + 2; end
      default: gap = -1;
    endcase
    if (gap >= 0) begin
      exp_addr.push_back(pc_m);
      exp_gap.push_back(gap);
    end
    @(posedge CLK); #1;
    MEM_ACK = 1'b0;
    MEM_RDATA = 16'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  logic [3:0] classes[6];
  initial begin
    classes = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8};
    RST = 1'b1; START = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = 16'h0000;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_state",   STATE,    3'd0);
    chk("rst_addr",    MEM_ADDR, 16'h0000);
    chk("rst_ir",      IR,       16'h0000);
    chk("rst_req",     MEM_REQ,  1'b0);
    chk("rst_we",      REG_WE,   1'b0);
    chk("rst_aluop",   ALU_OP,   2'b00);
    chk("rst_halted",  HALTED,   1'b0);
    chk("rst_illegal", ILLEGAL,  1'b0);
    chk("rst_wrap_pc", w_addr,   16'hFFFF);

    RST = 1'b0;
    model_init();
    mon_en = 1'b1;
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    chk("start_state", STATE,    3'd1);
    chk("start_req",   MEM_REQ,  1'b1);
    chk("start_addr",  MEM_ADDR, 16'h0000);
    chk("start_ir",    IR,       16'h0000);
    chk("start_we",    REG_WE,   1'b0);

    do_instr(16'h1234, 0);
    wait_req();
    chk("add_next_pc", MEM_ADDR, 16'h0001);
    chk("wrap_pc",     w_addr,   16'h0000);

    do_instr(16'h2ABC, 3);
    do_instr(16'h8F2A, 0);
    wait_req();
    chk("jmp_target", MEM_ADDR, 16'h002A);

    for (int i = 0; i < 150; i++)
      do_instr({classes[$urandom_range(0, 5)], 12'($urandom)}, $urandom_range(0, 3));

    do_instr(16'h7123, 1);
    for (int i = 0; i < 10; i++) begin
      START = (i % 3 == 0);
      @(posedge CLK); #1;
      chk("halt_req", MEM_REQ, 1'b0);
      chk("halt_we",  REG_WE,  1'b0);
    end
    START = 1'b0;
    chk("ill_halted",  HALTED,  1'b1);
    chk("ill_illegal", ILLEGAL, 1'b1);
    chk("ill_state",   STATE,   3'd5);
    chk("ill_pending", exp_addr.size() + exp_op.size() + exp_ir.size(), 0);

    reset_and_start();
    do_instr(16'h0ABC, 2);
    do_instr(16'hF000, 0);
    repeat (3) begin @(posedge CLK); #1; end
    chk("halt_halted",  HALTED,  1'b1);
    chk("halt_illegal", ILLEGAL, 1'b0);
    chk("halt_state",   STATE,   3'd5);
    chk("halt_req2",    MEM_REQ, 1'b0);

    reset_and_start();
    do_instr(16'h0555, 0);
    wait_req();
    mon_en = 1'b0;
    RST = 1'b1; MEM_ACK = 1'b1; MEM_RDATA = 16'h1234;
    @(posedge CLK); #1;
    RST = 1'b0; MEM_ACK = 1'b0;
    chk("midrst_state", STATE,    3'd0);
    chk("midrst_addr",  MEM_ADDR, 16'h0000);
    chk("midrst_ir",    IR,       16'h0000);
    chk("midrst_req",   MEM_REQ,  1'b0);
    chk("midrst_we",    REG_WE,   1'b0);
    @(posedge CLK); #1;
    chk("midrst_idle",  STATE,    3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
